// File: rtl/bs_slot_boot_ctrl.sv
// bs_slot_boot_ctrl: CRC-checks a flash bitstream slot, then commands an IPAL hot reboot into it.
// Define BS_SLOT_FALLBACK_EN to retry lower good slots after a CRC failure.
module bs_slot_boot_ctrl #(
    parameter int          SLOT_CNT    = 4,
    parameter logic [23:0] SLOT0_ADDR  = 24'h20_3000,
    parameter logic [23:0] SLOT_STRIDE = 24'h08_0000,
    parameter logic [31:0] TIMEOUT_CYC = 32'd25_000_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                open_req,
    input  logic [2:0]          open_slot,
    output logic                busy,
    output logic                crc_chk_req,
    output logic [2:0]          crc_chk_slot,
    input  logic [1:0]          crc_res,
    output logic                hotreset_en,
    output logic [23:0]         hotreset_addr,
    input  logic                ipal_done,
    output logic                done,
    output logic [2:0]          status,
    output logic [2:0]          cur_slot,
    output logic [SLOT_CNT-1:0] fail_mask
);
    typedef enum logic [2:0] {IDLE, CHECK, WAIT_CRC, NEXT, BOOT, WAIT_IPAL, FINISH} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cur_slot_q, cur_slot_d;
    logic [SLOT_CNT-1:0] fail_mask_q, fail_mask_d;
    logic [2:0]          status_q, status_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [23:0]         addr_q, addr_d;

`ifdef BS_SLOT_FALLBACK_EN
    logic       fb_found;
    logic [2:0] fb_slot;

    // ascending scan leaves the highest good slot below cur_slot
    always_comb begin
        fb_found = 1'b0;
        fb_slot  = 3'd0;
        for (int i = 0; i < SLOT_CNT; i++)
            if (3'(i) < cur_slot_q && !fail_mask_q[i]) begin
                fb_found = 1'b1;
                fb_slot  = 3'(i);
            end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cur_slot_d  = cur_slot_q;
        fail_mask_d = fail_mask_q;
        status_d    = status_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        case (state_q)
            IDLE:
                if (open_req) begin
                    if (32'(open_slot) < SLOT_CNT) begin
                        state_d     = CHECK;
                        cur_slot_d  = open_slot;
                        fail_mask_d = '0;
                        status_d    = 3'd0;
                    end else begin
                        state_d  = FINISH;
                        status_d = 3'd2;
                    end
                end
            CHECK: begin
                cnt_d   = '0;
                state_d = WAIT_CRC;
            end
            WAIT_CRC: begin
                cnt_d = cnt_q + 32'd1;
                if (crc_res == 2'b10) begin
                    state_d = BOOT;
                    addr_d  = SLOT0_ADDR + SLOT_STRIDE * {21'd0, cur_slot_q};
                end else if (crc_res == 2'b11) begin
                    state_d = NEXT;
                    for (int i = 0; i < SLOT_CNT; i++)
                        if (3'(i) == cur_slot_q) fail_mask_d[i] = 1'b1;
                end else if (cnt_q == TIMEOUT_CYC - 32'd1) begin
                    state_d  = FINISH;
                    status_d = 3'd3;
                end
            end
            NEXT: begin
`ifdef BS_SLOT_FALLBACK_EN
                state_d    = fb_found ? CHECK : FINISH;
                cur_slot_d = fb_found ? fb_slot : cur_slot_q;
                status_d   = fb_found ? status_q : 3'd4;
`else
                state_d  = FINISH;
                status_d = 3'd1;
`endif
            end
            BOOT: begin
                cnt_d   = '0;
                state_d = WAIT_IPAL;
            end
            WAIT_IPAL: begin
                cnt_d = cnt_q + 32'd1;
                if (ipal_done) begin
                    state_d  = FINISH;
                    status_d = 3'd0;
                end else if (cnt_q == TIMEOUT_CYC - 32'd1) begin
                    state_d  = FINISH;
                    status_d = 3'd3;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cur_slot_q  <= 3'd0;
            fail_mask_q <= '0;
            status_q    <= 3'd0;
            cnt_q       <= '0;
            addr_q      <= SLOT0_ADDR;
        end else begin
            state_q     <= state_d;
            cur_slot_q  <= cur_slot_d;
            fail_mask_q <= fail_mask_d;
            status_q    <= status_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
        end
    end

    assign busy          = state_q != IDLE && state_q != FINISH;
    assign crc_chk_req   = state_q == CHECK;
    assign crc_chk_slot  = cur_slot_q;
    assign hotreset_en   = state_q == BOOT;
    assign hotreset_addr = addr_q;
    assign done          = state_q == FINISH;
    assign status        = status_q;
    assign cur_slot      = cur_slot_q;
    assign fail_mask     = fail_mask_q;
endmodule

// File: tb/tb_bs_slot_boot_ctrl.sv
// tb_bs_slot_boot_ctrl: vector table plus directed sequences for bs_slot_boot_ctrl (SLOT_CNT=4, TIMEOUT_CYC=16).
module tb_bs_slot_boot_ctrl;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        open_req = 1'b0;
    logic [2:0]  open_slot = 3'd0;
    logic [1:0]  crc_res = 2'b00;
    logic        ipal_done = 1'b0;
    logic        busy, crc_chk_req, hotreset_en, done;
    logic [2:0]  crc_chk_slot, status, cur_slot;
    logic [23:0] hotreset_addr;
    logic [3:0]  fail_mask;
    logic [40:0] obs;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          hot_cnt = 0;

    typedef struct {
        logic        req;
        logic [2:0]  slot;
        logic [1:0]  crc;
        logic        ipal;
        logic [40:0] exp;
    } vec_t;
    vec_t tbl[16];

    bs_slot_boot_ctrl #(.SLOT_CNT(4), .TIMEOUT_CYC(32'd16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .open_req(open_req), .open_slot(open_slot),
        .busy(busy), .crc_chk_req(crc_chk_req), .crc_chk_slot(crc_chk_slot), .crc_res(crc_res),
        .hotreset_en(hotreset_en), .hotreset_addr(hotreset_addr), .ipal_done(ipal_done),
        .done(done), .status(status), .cur_slot(cur_slot), .fail_mask(fail_mask)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (hotreset_en) hot_cnt <= hot_cnt + 1;
    end

    assign obs = {busy, crc_chk_req, crc_chk_slot, hotreset_en, done, status, cur_slot, fail_mask, hotreset_addr};

    function automatic logic [40:0] ev(input logic b, input logic cr, input logic h, input logic d,
                                       input logic [2:0] st, input logic [2:0] cs,
                                       input logic [3:0] fm, input logic [23:0] a);
        return {b, cr, cs, h, d, st, cs, fm, a};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic go(input logic [2:0] s);
        open_req  = 1'b1;
        open_slot = s;
        tick();
        open_req  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        int h0;
        tbl[0]  = '{1'b1, 3'd2, 2'b00, 1'b0, ev(1, 1, 0, 0, 3'd0, 3'd2, 4'd0, 24'h20_3000)};
        tbl[1]  = '{1'b0, 3'd0, 2'b00, 1'b0, ev(1, 0, 0, 0, 3'd0, 3'd2, 4'd0, 24'h20_3000)};
        tbl[2]  = '{1'b0, 3'd0, 2'b00, 1'b1, ev(1, 0, 0, 0, 3'd0, 3'd2, 4'd0, 24'h20_3000)};
        tbl[3]  = '{1'b1, 3'd1, 2'b00, 1'b0, ev(1, 0, 0, 0, 3'd0, 3'd2, 4'd0, 24'h20_3000)};
        tbl[4]  = '{1'b0, 3'd0, 2'b10, 1'b0, ev(1, 0, 1, 0, 3'd0, 3'd2, 4'd0, 24'h30_3000)};
        tbl[5]  = '{1'b0, 3'd0, 2'b11, 1'b0, ev(1, 0, 0, 0, 3'd0, 3'd2, 4'd0, 24'h30_3000)};
        tbl[6]  = '{1'b0, 3'd0, 2'b00, 1'b1, ev(0, 0, 0, 1, 3'd0, 3'd2, 4'd0, 24'h30_3000)};
        tbl[7]  = '{1'b0, 3'd0, 2'b00, 1'b0, ev(0, 0, 0, 0, 3'd0, 3'd2, 4'd0, 24'h30_3000)};
        tbl[8]  = '{1'b1, 3'd5, 2'b00, 1'b0, ev(0, 0, 0, 1, 3'd2, 3'd2, 4'd0, 24'h30_3000)};
        tbl[9]  = '{1'b0, 3'd0, 2'b00, 1'b0, ev(0, 0, 0, 0, 3'd2, 3'd2, 4'd0, 24'h30_3000)};
        tbl[10] = '{1'b1, 3'd3, 2'b00, 1'b0, ev(1, 1, 0, 0, 3'd0, 3'd3, 4'd0, 24'h30_3000)};
        tbl[11] = '{1'b0, 3'd0, 2'b00, 1'b0, ev(1, 0, 0, 0, 3'd0, 3'd3, 4'd0, 24'h30_3000)};
        tbl[12] = '{1'b0, 3'd0, 2'b10, 1'b0, ev(1, 0, 1, 0, 3'd0, 3'd3, 4'd0, 24'h38_3000)};
        tbl[13] = '{1'b0, 3'd0, 2'b00, 1'b0, ev(1, 0, 0, 0, 3'd0, 3'd3, 4'd0, 24'h38_3000)};
        tbl[14] = '{1'b0, 3'd0, 2'b00, 1'b1, ev(0, 0, 0, 1, 3'd0, 3'd3, 4'd0, 24'h38_3000)};
        tbl[15] = '{1'b0, 3'd0, 2'b00, 1'b0, ev(0, 0, 0, 0, 3'd0, 3'd3, 4'd0, 24'h38_3000)};

        repeat (3) tick();
        chk("reset", 64'(obs), 64'(ev(0, 0, 0, 0, 3'd0, 3'd0, 4'd0, 24'h20_3000)));
        sys_rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            open_req  = tbl[i].req;
            open_slot = tbl[i].slot;
            crc_res   = tbl[i].crc;
            ipal_done = tbl[i].ipal;
            tick();
            chk($sformatf("vec%0d", i), 64'(obs), 64'(tbl[i].exp));
        end
        open_req  = 1'b0;
        crc_res   = 2'b00;
        ipal_done = 1'b0;
        tick();

        // slot 1 then slot 0 both fail
        h0 = hot_cnt;
        go(3'd1);
        tick();
        crc_res = 2'b11;
        tick();
        crc_res = 2'b00;
        chk("err_mask1", 64'(fail_mask), 64'(4'b0010));
`ifdef BS_SLOT_FALLBACK_EN
        tick();
        chk("err_fb_check", 64'({crc_chk_req, crc_chk_slot}), 64'({1'b1, 3'd0}));
        tick();
        crc_res = 2'b11;
        tick();
        crc_res = 2'b00;
        tick();
        chk("err_finish", 64'({done, busy, status, fail_mask}), 64'({1'b1, 1'b0, 3'd4, 4'b0011}));
`else
        tick();
        chk("err_finish", 64'({done, busy, status, fail_mask}), 64'({1'b1, 1'b0, 3'd1, 4'b0010}));
`endif
        chk("err_no_hotreset", 64'(hot_cnt), 64'(h0));
        tick();

        // slot 3 fails, fallback boots slot 2
        go(3'd3);
        tick();
        crc_res = 2'b11;
        tick();
        crc_res = 2'b00;
`ifdef BS_SLOT_FALLBACK_EN
        tick();
        chk("fb_check2", 64'({crc_chk_req, crc_chk_slot}), 64'({1'b1, 3'd2}));
        tick();
        crc_res = 2'b10;
        tick();
        crc_res = 2'b00;
        chk("fb_boot", 64'({hotreset_en, hotreset_addr}), 64'({1'b1, 24'h30_3000}));
        tick();
        ipal_done = 1'b1;
        tick();
        ipal_done = 1'b0;
        chk("fb_finish", 64'({done, status, fail_mask}), 64'({1'b1, 3'd0, 4'b1000}));
`else
        tick();
        chk("nofb_finish", 64'({done, status, fail_mask}), 64'({1'b1, 3'd1, 4'b1000}));
`endif
        tick();

        // CRC timeout: done exactly 16 cycles after entering WAIT_CRC
        go(3'd1);
        tick();
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", 64'(n), 64'(16));
        chk("to_status", 64'({done, status}), 64'({1'b1, 3'd3}));
        tick();
        chk("to_done_pulse", 64'({done, busy}), 64'({1'b0, 1'b0}));

        // response on the expiry cycle wins over the timeout
        go(3'd2);
        tick();
        repeat (15) tick();
        chk("pri_not_done", 64'({done, busy}), 64'({1'b0, 1'b1}));
        crc_res = 2'b10;
        tick();
        crc_res = 2'b00;
        chk("pri_boot", 64'({hotreset_en, hotreset_addr}), 64'({1'b1, 24'h30_3000}));
        tick();
        ipal_done = 1'b1;
        tick();
        ipal_done = 1'b0;
        chk("pri_finish", 64'({done, status}), 64'({1'b1, 3'd0}));
        tick();

        // reset during WAIT_IPAL aborts without done
        go(3'd1);
        tick();
        crc_res = 2'b10;
        tick();
        crc_res = 2'b00;
        chk("rst_boot_addr", 64'(hotreset_addr), 64'(24'h28_3000));
        tick();
        chk("rst_in_wait", 64'({busy, hotreset_en}), 64'({1'b1, 1'b0}));
        d0 = done_cnt;
        sys_rst = 1'b1;
        tick();
        chk("rst_outputs", 64'(obs), 64'(ev(0, 0, 0, 0, 3'd0, 3'd0, 4'd0, 24'h20_3000)));
        ipal_done = 1'b1;
        tick();
        sys_rst = 1'b0;
        repeat (3) tick();
        ipal_done = 1'b0;
        repeat (5) tick();
        chk("rst_no_done", 64'(done_cnt), 64'(d0));
        chk("rst_idle", 64'(obs), 64'(ev(0, 0, 0, 0, 3'd0, 3'd0, 4'd0, 24'h20_3000)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bs_slot_boot_ctrl.md
BS_SLOT_BOOT_CTRL -- requirements
Module: bs_slot_boot_ctrl

Interface
REQ-001 The block SHALL have parameter SLOT_CNT, default 4, giving the number of user bitstream slots in flash (legal 1..8).
REQ-002 The block SHALL have parameter SLOT0_ADDR, default 24'h20_3000, giving the slot 0 flash start address (4KB aligned).
REQ-003 The block SHALL have parameter SLOT_STRIDE, default 24'h08_0000, giving the address distance between consecutive slots.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 32'd25_000_000, giving the wait limit in cycles (1 s at 25 MHz).
REQ-005 The block SHALL have port sys_clk, input, 1 bit: the single clock (25 MHz domain).
REQ-006 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port open_req, input, 1 bit: single-cycle pulse requesting a boot of open_slot.
REQ-008 The block SHALL have port open_slot, input, 3 bits: the requested slot index.
REQ-009 The block SHALL have port busy, output, 1 bit: high from an accepted request until done.
REQ-010 The block SHALL have ports crc_chk_req (output, 1 bit, pulse) and crc_chk_slot (output, 3 bits): CRC check request to the flash controller.
REQ-011 The block SHALL have port crc_res, input, 2 bits: [1] result valid; [0] 0 = OK, 1 = error.
REQ-012 The block SHALL have ports hotreset_en (output, 1 bit, pulse) and hotreset_addr (output, 24 bits): the IPAL reboot command.
REQ-013 The block SHALL have port ipal_done, input, 1 bit: pulse from IPAL acknowledging the reboot command.
REQ-014 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-015 The block SHALL have port status, output, 3 bits: 0 OK, 1 CRC fail, 2 range error, 3 timeout, 4 all slots bad.
REQ-016 The block SHALL have ports cur_slot (output, 3 bits) and fail_mask (output, SLOT_CNT bits): the slot under test and the slots found bad.

Function
REQ-017 The FSM SHALL have states IDLE, CHECK, WAIT_CRC, NEXT, BOOT, WAIT_IPAL and FINISH.
REQ-018 In IDLE, an open_req with open_slot<SLOT_CNT SHALL latch cur_slot, clear fail_mask, set busy and go to CHECK.
REQ-019 In IDLE, an open_req with open_slot>=SLOT_CNT SHALL produce done plus status=2 one cycle later, with busy staying low.
REQ-020 open_req while busy SHALL be ignored.
REQ-021 CHECK SHALL pulse crc_chk_req for exactly 1 cycle with crc_chk_slot=cur_slot, then enter WAIT_CRC with the timeout counter cleared.
REQ-022 In WAIT_CRC, crc_res=2'b10 SHALL go to BOOT, and crc_res=2'b11 SHALL set fail_mask[cur_slot] and go to NEXT.
REQ-023 BOOT SHALL drive hotreset_addr=SLOT0_ADDR+cur_slot*SLOT_STRIDE (24-bit, wraps mod 2^24), pulse hotreset_en for 1 cycle and enter WAIT_IPAL.
REQ-024 hotreset_addr SHALL hold its value until the next BOOT.
REQ-025 WAIT_IPAL SHALL move to FINISH on ipal_done, with status=0.
REQ-026 The timeout counter SHALL run in WAIT_CRC and WAIT_IPAL; on reaching TIMEOUT_CYC-1 without a response the block SHALL go to FINISH with status=3.
REQ-027 A response arriving in the same cycle as timeout expiry SHALL take priority over the timeout.
REQ-028 FINISH SHALL pulse done for 1 cycle, drop busy in the same cycle and return to IDLE.
REQ-029 status and fail_mask SHALL hold until the next accepted request.
REQ-030 crc_res or ipal_done arriving outside its wait state SHALL be ignored.

Reset
REQ-031 While sys_rst is high, the FSM SHALL be in IDLE and busy, crc_chk_req, hotreset_en and done SHALL be 0.
REQ-032 While sys_rst is high, crc_chk_slot, cur_slot, status, fail_mask and the counter SHALL be 0, and hotreset_addr SHALL be SLOT0_ADDR.
REQ-033 Reset asserted mid-operation SHALL abort immediately with no hotreset_en or done pulse issued.

Configuration
REQ-034 With macro BS_SLOT_FALLBACK_EN defined, NEXT SHALL select the highest index j<cur_slot with fail_mask[j]=0, set cur_slot=j and go to CHECK.
REQ-035 With BS_SLOT_FALLBACK_EN defined and no such j (cur_slot=0 included), NEXT SHALL go to FINISH with status=4.
REQ-036 Without BS_SLOT_FALLBACK_EN, NEXT SHALL go directly to FINISH with status=1 and no fallback logic SHALL be built.

Verification
REQ-037 The bench SHALL cover: open_slot=2, crc_res=2'b10 -> crc_chk_slot=2, hotreset_addr=24'h30_3000, hotreset_en 1 pulse; after ipal_done -> done, status=0.
REQ-038 The bench SHALL cover: open_slot=5 with SLOT_CNT=4 -> done 1 cycle later, status=2, no crc_chk_req.
REQ-039 The bench SHALL cover, with fallback: slot 3 returns 2'b11, slot 2 returns 2'b10 -> fail_mask=4'b1000, hotreset_addr=24'h30_3000, status=0.
REQ-040 The bench SHALL cover: slot 1 and then slot 0 both return errors -> status=4 with fallback, status=1 without, and hotreset_en never asserted.
REQ-041 The bench SHALL cover, with TIMEOUT_CYC=16: no crc_res -> done exactly 16 cycles after entering WAIT_CRC, status=3.
REQ-042 The bench SHALL cover: sys_rst pulsed while in WAIT_IPAL -> all outputs at reset values, and no done ever issued for the aborted request.
